// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM serializer.
// Holds the FSM state encoding, last-beat index and mux select helper.
package tdm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [1:0] CNT_LAST = 2'd3;

  // Beat counter to channel index; MSB-first walks the word downwards.
  function automatic logic [1:0] mux_sel(
    input logic       lsb_first,
    input logic [1:0] cnt
  );
    return lsb_first ? cnt : ~cnt;
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Gate-level 2:1 mux, y = s ? b : a.
// Ports: a_i, b_i data; s_i select; y_o output.
module mux2to1 (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);

  wire s_n;
  wire t_a;
  wire t_b;

  not u_inv (s_n, s_i);
  and u_and_a (t_a, a_i, s_n);
  and u_and_b (t_b, b_i, s_i);
  or  u_or (y_o, t_a, t_b);

endmodule

// File: rtl/mux4to1.sv
// 4:1 channel mux built as a two-level tree of 2:1 muxes.
// Ports: data_i[3:0] channel bits, sel_i[1:0] channel index, y_o bit.
module mux4to1 (
  input  logic [3:0] data_i,
  input  logic [1:0] sel_i,
  output logic       y_o
);

  logic lo;
  logic hi;

  mux2to1 u_lo (
    .a_i (data_i[0]),
    .b_i (data_i[1]),
    .s_i (sel_i[0]),
    .y_o (lo)
  );

  mux2to1 u_hi (
    .a_i (data_i[2]),
    .b_i (data_i[3]),
    .s_i (sel_i[0]),
    .y_o (hi)
  );

  mux2to1 u_top (
    .a_i (lo),
    .b_i (hi),
    .s_i (sel_i[1]),
    .y_o (y_o)
  );

endmodule

// File: rtl/tdm_serializer.sv
// 4-bit parallel word to 1-bit TDM stream, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_data/in_ready, out_valid/out_ready,
// out_bit/out_sof/out_eof, busy.
import tdm_pkg::*;

module tdm_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] hold_q, hold_d;
  logic       rdy_en_q;

  logic       in_hs;
  logic       out_hs;
  logic       last;
  logic [1:0] sel;

  assign last      = (cnt_q == CNT_LAST);
  assign busy      = (state_q == ST_SEND);
  assign out_valid = busy;

  // rdy_en_q keeps in_ready low until the first edge after reset.
  // In SEND only the last-beat handshake frees the hold register.
  assign in_ready = busy ? (last && out_ready) : rdy_en_q;

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign out_sof = out_valid && (cnt_q == 2'd0);
  assign out_eof = out_valid && last;
  assign sel     = mux_sel(LSB_FIRST, cnt_q);

  mux4to1 u_mux (
    .data_i (hold_q),
    .sel_i  (sel),
    .y_o    (out_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_hs) begin
          if (!last) begin
            cnt_d = cnt_q + 2'd1;
          end else if (in_hs) begin
            hold_d = in_data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule
